// File: rtl/tt_pkg.sv
// Shared types and the index-to-port mapping for the truth-table extractor.
// The bench reference model uses the same mapping.
package tt_pkg;

  localparam int TT_W  = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  typedef struct packed {
    logic in1;
    logic in2;
    logic in3;
    logic in4;
  } dut_inputs_t;

  // in1 carries the most significant index bit.
  function automatic dut_inputs_t idx_to_inputs(input logic [IDX_W-1:0] k);
    dut_inputs_t r;
    r.in1 = k[3];
    r.in2 = k[2];
    r.in3 = k[1];
    r.in4 = k[0];
    return r;
  endfunction

endpackage

// File: rtl/tt_sample_window.sv
// Settle/sample timing and stability compare for one input combination.
// A single counter serves both phases and is cleared at the end of each phase.
module tt_sample_window #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_SAMPLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_settle,
  input  logic in_sample,
  input  logic dut_out,
  output logic settle_done,
  output logic sample_en,
  output logic first_sample,
  output logic differ,
  output logic window_done
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  always_comb begin
    cnt_d        = '0;
    first_d      = first_q;
    settle_done  = in_settle && (cnt_q == SETTLE_LAST);
    sample_en    = in_sample;
    first_sample = in_sample && (cnt_q == '0);
    window_done  = in_sample && (cnt_q == SAMPLE_LAST);
    // Later samples are compared against the stored first sample.
    differ       = in_sample && (cnt_q != '0) && (dut_out != first_q);
    if (first_sample) first_d = dut_out;
    if ((in_settle && !settle_done) || (in_sample && !window_done)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/truth_table_extractor.sv
// Steps a 4-input netlist through all 16 combinations, assembles its truth
// table, compares it against an expected ID and flags unstable outputs.
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int STABLE_SAMPLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [TT_W-1:0] expected_id,
  output logic            dut_in1,
  output logic            dut_in2,
  output logic            dut_in3,
  output logic            dut_in4,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] table_id,
  output logic            match,
  output logic [TT_W-1:0] unstable
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic [TT_W-1:0]   table_q, table_d;
  logic [TT_W-1:0]   unstable_q, unstable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  dut_inputs_t       in_q, in_d;

  logic settle_done, sample_en, first_sample, differ, window_done;

  tt_sample_window #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .STABLE_SAMPLES(STABLE_SAMPLES)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_settle   (state_q == SETTLE),
    .in_sample   (state_q == SAMPLE),
    .dut_out     (dut_out),
    .settle_done (settle_done),
    .sample_en   (sample_en),
    .first_sample(first_sample),
    .differ      (differ),
    .window_done (window_done)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    exp_d      = exp_q;
    table_d    = table_q;
    unstable_d = unstable_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    match_d    = match_q;
    in_d       = in_q;
    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is dropped, not queued.
        if (start && !done_q) begin
          exp_d      = expected_id;
          table_d    = '0;
          unstable_d = '0;
          match_d    = 1'b0;
          k_d        = '0;
          in_d       = idx_to_inputs('0);
          busy_d     = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (sample_en && first_sample) table_d[k_q] = dut_out;
        if (differ) unstable_d[k_q] = 1'b1;
        if (window_done) begin
          if (k_q == IDX_W'(TT_W - 1)) begin
            state_d = FINISH;
          end else begin
            k_d     = k_q + 1'b1;
            in_d    = idx_to_inputs(k_d);
            state_d = SETTLE;
          end
        end
      end
      FINISH: begin
        match_d = (table_q == exp_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      exp_q      <= '0;
      table_q    <= '0;
      unstable_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      in_q       <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      exp_q      <= exp_d;
      table_q    <= table_d;
      unstable_q <= unstable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      match_q    <= match_d;
      in_q       <= in_d;
    end
  end

  assign dut_in1  = in_q.in1;
  assign dut_in2  = in_q.in2;
  assign dut_in3  = in_q.in3;
  assign dut_in4  = in_q.in4;
  assign busy     = busy_q;
  assign done     = done_q;
  assign table_id = table_q;
  assign match    = match_q;
  assign unstable = unstable_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench for truth_table_extractor: default-parameter instance for the
// main runs, plus a fast instance (settle 1, sample 1) for the stepping check.
module tb_truth_table_extractor;
  import tt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_a = 1'b0;
  logic [15:0] exp_a = '0;
  logic        a_in1, a_in2, a_in3, a_in4;
  logic        dut_out_a;
  logic        busy_a, done_a, match_a;
  logic [15:0] table_a, unstable_a;
  int          func_a = 0;
  logic        glitch_a = 1'b0;

  logic        start_b = 1'b0;
  logic [15:0] exp_b = '0;
  logic        b_in1, b_in2, b_in3, b_in4;
  logic        dut_out_b;
  logic        busy_b, done_b, match_b;
  logic [15:0] table_b, unstable_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  truth_table_extractor u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected_id(exp_a),
    .dut_in1(a_in1), .dut_in2(a_in2), .dut_in3(a_in3), .dut_in4(a_in4),
    .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .table_id(table_a),
    .match(match_a), .unstable(unstable_a)
  );

  truth_table_extractor #(.SETTLE_CYCLES(1), .STABLE_SAMPLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected_id(exp_b),
    .dut_in1(b_in1), .dut_in2(b_in2), .dut_in3(b_in3), .dut_in4(b_in4),
    .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .table_id(table_b),
    .match(match_b), .unstable(unstable_b)
  );

  // Bench netlists: 0 = in1&in2, 1 = parity, 2 = constant 0, 3 = in4.
  function automatic logic model_out(input int func, input logic [3:0] v);
    case (func)
      0:       return v[3] & v[2];
      1:       return ^v;
      2:       return 1'b0;
      default: return v[0];
    endcase
  endfunction

  always_comb dut_out_a = model_out(func_a, {a_in1, a_in2, a_in3, a_in4}) ^ glitch_a;
  always_comb dut_out_b = model_out(3, {b_in1, b_in2, b_in3, b_in4});

  typedef struct {
    string       name;
    logic [15:0] exp_id;
    int          func;
    int          glitch_k;
    logic [15:0] want_table;
    logic        want_match;
    logic [15:0] want_unstable;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, want);
    end
  endtask

  // Runs one extraction on instance A; returns latency in cycles or -1.
  task automatic applyStimulus(input logic [15:0] exp_id, input int func, input int glitch_k,
                               input bit restart_pulses, output int latency);
    int gedge;
    gedge   = 6 * glitch_k + 5;
    latency = -1;
    func_a  = func;
    @(posedge clk); #1;
    start_a = 1'b1;
    exp_a   = exp_id;
    @(posedge clk); #1;
    start_a = 1'b0;
    checkOutput("busy after start", 16'(busy_a), 16'h1);
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (glitch_k >= 0 && n == gedge) glitch_a = 1'b1;
      if (glitch_k >= 0 && n == gedge + 1) glitch_a = 1'b0;
      if (restart_pulses && (n == 10 || n == 50)) begin
        start_a = 1'b1;
        exp_a   = 16'h0000;
      end else begin
        start_a = 1'b0;
      end
      if (done_a) begin
        latency = n + 1;
        break;
      end
    end
    if (latency < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done timeout: got none, expected done within 200 cycles");
    end else begin
      checkOutput("busy low at done", 16'(busy_a), 16'h0);
    end
  endtask

  initial begin
    int lat;
    int done_cnt;
    logic [3:0] want_in;

    vecs[0] = '{"and_F000",   16'hF000, 0, -1, 16'hF000, 1'b1, 16'h0000};
    vecs[1] = '{"xor_6996",   16'h6996, 1, -1, 16'h6996, 1'b1, 16'h0000};
    vecs[2] = '{"xor_6997",   16'h6997, 1, -1, 16'h6996, 1'b0, 16'h0000};
    vecs[3] = '{"glitch_k5",  16'h0000, 2,  5, 16'h0000, 1'b1, 16'h0020};

    #2;
    checkOutput("reset dut_in", 16'({a_in1, a_in2, a_in3, a_in4}), 16'h0);
    checkOutput("reset busy", 16'(busy_a), 16'h0);
    checkOutput("reset done", 16'(done_a), 16'h0);
    checkOutput("reset table", table_a, 16'h0);
    checkOutput("reset match", 16'(match_a), 16'h0);
    checkOutput("reset unstable", unstable_a, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].exp_id, vecs[i].func, vecs[i].glitch_k, 1'b0, lat);
      checkOutput({vecs[i].name, " latency"}, 16'(lat), 16'd98);
      checkOutput({vecs[i].name, " table"}, table_a, vecs[i].want_table);
      checkOutput({vecs[i].name, " match"}, 16'(match_a), 16'(vecs[i].want_match));
      checkOutput({vecs[i].name, " unstable"}, unstable_a, vecs[i].want_unstable);
      checkOutput({vecs[i].name, " hold comb 15"}, 16'({a_in1, a_in2, a_in3, a_in4}), 16'hF);
      @(posedge clk); #1;
      checkOutput({vecs[i].name, " done one cycle"}, 16'(done_a), 16'h0);
      checkOutput({vecs[i].name, " table stable"}, table_a, vecs[i].want_table);
    end

    // Restart pulses mid-run must be ignored and not requeued.
    applyStimulus(16'h6996, 1, -1, 1'b1, lat);
    checkOutput("restart latency", 16'(lat), 16'd98);
    checkOutput("restart match kept", 16'(match_a), 16'h1);
    done_cnt = 0;
    for (int n = 0; n < 110; n++) begin
      @(posedge clk); #1;
      if (done_a) done_cnt++;
    end
    checkOutput("restart no extra done", 16'(done_cnt), 16'h0);

    // Reset mid-run at cycle 40 aborts immediately.
    func_a = 1;
    @(posedge clk); #1;
    start_a = 1'b1;
    exp_a   = 16'h6996;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("pre-reset partial table", table_a, 16'h0016);
    checkOutput("pre-reset dut_in", 16'({a_in1, a_in2, a_in3, a_in4}), 16'h6);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 16'(busy_a), 16'h0);
    checkOutput("abort dut_in", 16'({a_in1, a_in2, a_in3, a_in4}), 16'h0);
    checkOutput("abort table", table_a, 16'h0);
    checkOutput("abort unstable", unstable_a, 16'h0);
    done_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      if (done_a) done_cnt++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk); #1;
      if (done_a) done_cnt++;
    end
    checkOutput("abort no done", 16'(done_cnt), 16'h0);
    applyStimulus(16'h6996, 1, -1, 1'b0, lat);
    checkOutput("post-reset latency", 16'(lat), 16'd98);
    checkOutput("post-reset table", table_a, 16'h6996);
    checkOutput("post-reset match", 16'(match_a), 16'h1);

    // Fast instance: inputs must step 0..15, one combination every 2 cycles.
    @(posedge clk); #1;
    start_b = 1'b1;
    exp_b   = 16'hAAAA;
    @(posedge clk); #1;
    start_b = 1'b0;
    want_in = idx_to_inputs(4'd0);
    checkOutput("fast comb 0", 16'({b_in1, b_in2, b_in3, b_in4}), 16'(want_in));
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n % 2 == 0 && n <= 30) begin
        want_in = idx_to_inputs(4'(n / 2));
        checkOutput("fast comb step", 16'({b_in1, b_in2, b_in3, b_in4}), 16'(want_in));
      end
      if (done_b) begin
        lat = n + 1;
        break;
      end
    end
    checkOutput("fast latency", 16'(lat), 16'd34);
    checkOutput("fast table", table_b, 16'hAAAA);
    checkOutput("fast match", 16'(match_b), 16'h1);
    checkOutput("fast unstable", unstable_b, 16'h0);
    checkOutput("fast hold comb 15", 16'({b_in1, b_in2, b_in3, b_in4}), 16'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
